thread_pc_unit: RTL

//  - Producer side of the barrel-thread fetch path: owns the four per-thread program counters and drives

---
 rtl/aurora_thread_pkg.sv | 13 +
 rtl/thread_pc_slot.sv | 47 ++++
 rtl/thread_pc_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/aurora_thread_pkg.sv
// Shared thread identifiers for the barrel-thread fetch path (PC unit and selector).
package aurora_thread_pkg;

  localparam int NUM_THREADS = 4;

  typedef logic [1:0] tid_t;

  localparam tid_t THREAD0 = 2'b00;
  localparam tid_t THREAD1 = 2'b01;
  localparam tid_t THREAD2 = 2'b10;
  localparam tid_t THREAD3 = 2'b11;

endpackage

// File: rtl/thread_pc_slot.sv
// One thread's program counter and active bit; resolves branch > halt > increment priority.
module thread_pc_slot #(
  parameter int           W            = 8,
  parameter logic [W-1:0] RESET_PC     = '0,
  parameter logic         RESET_ACTIVE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         br_hit_i,
  input  logic         halt_hit_i,
  input  logic         start_i,
  input  logic         inc_i,
  input  logic [W-1:0] br_target_i,
  output logic [W-1:0] pc_o,
  output logic         active_o
);

  logic [W-1:0] pc_q, pc_d;
  logic         active_q, active_d;

  always_comb begin
    pc_d     = pc_q;
    active_d = active_q;
    // Halt is applied after start so a same-cycle halt wins.
    if (start_i)    active_d = 1'b1;
    if (halt_hit_i) active_d = 1'b0;
    if (br_hit_i) begin
      pc_d = br_target_i;
    end else if (!halt_hit_i && inc_i && active_q) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      active_q <= RESET_ACTIVE;
    end else begin
      pc_q     <= pc_d;
      active_q <= active_d;
    end
  end

  assign pc_o     = pc_q;
  assign active_o = active_q;

endmodule

// File: rtl/thread_pc_unit.sv
// Per-thread PC owner for the barrel fetch path: tid decode, four PC slots, fetch_ok mux, redirect pulse.
module thread_pc_unit
  import aurora_thread_pkg::*;
#(
  parameter int                           INSTMEM_LOG2_DEEP = 8,
  parameter logic [INSTMEM_LOG2_DEEP-1:0] RESET_PC          = '0,
  parameter logic [3:0]                   RESET_ACTIVE      = 4'hF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         fetch_en_i,
  input  logic [1:0]                   fetch_tid_i,
  input  logic                         br_valid_i,
  input  logic [1:0]                   br_tid_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] br_target_i,
  input  logic                         halt_valid_i,
  input  logic [1:0]                   halt_tid_i,
  input  logic [3:0]                   start_i,
  output logic [INSTMEM_LOG2_DEEP-1:0] thread0_pc_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] thread1_pc_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] thread2_pc_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] thread3_pc_o,
  output logic [3:0]                   thread_active_o,
  output logic                         fetch_ok_o,
  output logic                         redirect_o,
  output logic [1:0]                   redirect_tid_o
);

  localparam int W = INSTMEM_LOG2_DEEP;

  logic [W-1:0]           pc_w [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_w;
  logic [NUM_THREADS-1:0] br_hit, halt_hit, inc;

  logic       redirect_q, redirect_d;
  logic [1:0] redirect_tid_q, redirect_tid_d;

  always_comb begin
    br_hit   = '0;
    halt_hit = '0;
    inc      = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      br_hit[t]   = br_valid_i   && (br_tid_i    == 2'(t));
      halt_hit[t] = halt_valid_i && (halt_tid_i  == 2'(t));
      inc[t]      = fetch_en_i   && (fetch_tid_i == 2'(t));
    end
  end

  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
    thread_pc_slot #(
      .W            (W),
      .RESET_PC     (RESET_PC),
      .RESET_ACTIVE (RESET_ACTIVE[g])
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .br_hit_i    (br_hit[g]),
      .halt_hit_i  (halt_hit[g]),
      .start_i     (start_i[g]),
      .inc_i       (inc[g]),
      .br_target_i (br_target_i),
      .pc_o        (pc_w[g]),
      .active_o    (active_w[g])
    );
  end

  // Redirect tid is sticky so downstream can read it without qualifying on redirect_o.
  always_comb begin
    redirect_d     = br_valid_i;
    redirect_tid_d = redirect_tid_q;
    if (br_valid_i) redirect_tid_d = br_tid_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_q     <= 1'b0;
      redirect_tid_q <= 2'b00;
    end else begin
      redirect_q     <= redirect_d;
      redirect_tid_q <= redirect_tid_d;
    end
  end

  assign thread0_pc_o    = pc_w[THREAD0];
  assign thread1_pc_o    = pc_w[THREAD1];
  assign thread2_pc_o    = pc_w[THREAD2];
  assign thread3_pc_o    = pc_w[THREAD3];
  assign thread_active_o = active_w;
  assign fetch_ok_o      = active_w[fetch_tid_i];
  assign redirect_o      = redirect_q;
  assign redirect_tid_o  = redirect_tid_q;

endmodule
